id_stage_pipe: RTL

//  Parametrised MIPS decode stage with registered ID/EX output. Reads the 32-entry register file,

---
 rtl/id_stage_pipe_pkg.sv | 50 +++++
 rtl/id_stage_pipe_regfile.sv | 57 +++++
 rtl/id_stage_pipe.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared definitions for the MIPS decode stage: opcode/funct encodings, control
// bundle layout and small instruction-field helpers.
package id_stage_pipe_pkg;

  localparam int unsigned CTRL_W = 12;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  // Bit offsets inside the opaque control bundle consumed by EX/MEM/WB
  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_TO_REG = 1;
  localparam int unsigned CTRL_MEM_READ   = 2;
  localparam int unsigned CTRL_MEM_WRITE  = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_REG_DST    = 5;
  localparam int unsigned CTRL_ALU_OP_LSB = 6;
  localparam int unsigned CTRL_ALU_OP_W   = 4;
  localparam int unsigned CTRL_LINK       = 10;

  typedef enum logic [2:0] {
    RDIR_NONE = 3'd0,
    RDIR_JR   = 3'd1,
    RDIR_JUMP = 3'd2,
    RDIR_BEQ  = 3'd3,
    RDIR_BNE  = 3'd4
  } redir_src_e;

  function automatic logic [4:0] inst_rs(input logic [31:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] inst_rt(input logic [31:0] inst);
    return inst[20:16];
  endfunction

  function automatic logic [4:0] inst_rd(input logic [31:0] inst);
    return inst[15:11];
  endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// 32-entry 2-read/1-write register file; r0 is hardwired to zero and the
// same-cycle write can optionally bypass onto the read ports.
module id_regfile
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter bit          RF_WRITE_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] mem_r [32];

  // Storage: cleared on reset, writes to r0 dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port A with optional write-first bypass
  always_comb begin
    rdata_a = '0;
    if (raddr_a == REG_ZERO) begin
      rdata_a = '0;
    end else if (RF_WRITE_FIRST && we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = mem_r[raddr_a];
    end
  end

  // Read port B with optional write-first bypass
  always_comb begin
    rdata_b = '0;
    if (raddr_b == REG_ZERO) begin
      rdata_b = '0;
    end else if (RF_WRITE_FIRST && we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = mem_r[raddr_b];
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: RF read with MEM/WB forwarding, branch/jump resolution in ID,
// load-use and branch hazard stalls, and the registered ID/EX boundary.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned CTRL_W         = id_stage_pipe_pkg::CTRL_W,
  parameter bit          RF_WRITE_FIRST = 1'b1,
  parameter bit          HAS_BNE        = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   pc4_i,
  input  logic [31:0]       inst_i,
  input  logic              sext_i,
  input  logic              is_beq_i,
  input  logic              is_bne_i,
  input  logic              is_jump_i,
  input  logic              is_jr_i,
  input  logic              uses_rs_i,
  input  logic              uses_rt_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              ex_we_i,
  input  logic              ex_is_load_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              mem_we_i,
  input  logic              mem_is_load_i,
  input  logic [4:0]        mem_rd_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              stall_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   pc_next_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc4_o,
  output logic [XLEN-1:0]   ex_rs_data_o,
  output logic [XLEN-1:0]   ex_rt_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [4:0]        ex_rs_o,
  output logic [4:0]        ex_rt_o,
  output logic [4:0]        ex_rd_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [15:0]       stall_cnt_o
);

  logic [4:0]      rs_addr_s, rt_addr_s, rd_addr_s;
  logic [XLEN-1:0] rf_rs_data_s, rf_rt_data_s;
  logic [XLEN-1:0] rs_fwd_s, rt_fwd_s;
  logic [XLEN-1:0] imm_s, br_target_s, jmp_target_s;
  logic            bne_eff_s, is_br_s, eq_s;
  logic            haz_rs_s, haz_rt_s, stall_s, redirect_s;
  logic [XLEN-1:0] pc_next_s;
  redir_src_e      redir_src_s;
  logic            unused_s;

  logic              ex_valid_r;
  logic [XLEN-1:0]   ex_pc4_r, ex_rs_data_r, ex_rt_data_r, ex_imm_r;
  logic [4:0]        ex_rs_r, ex_rt_r, ex_rd_r;
  logic [CTRL_W-1:0] ex_ctrl_r;
  logic [15:0]       stall_cnt_r;

  assign rs_addr_s = inst_rs(inst_i);
  assign rt_addr_s = inst_rt(inst_i);
  assign rd_addr_s = inst_rd(inst_i);
  assign unused_s  = ^inst_i[31:26];

  id_regfile #(
    .XLEN           (XLEN),
    .RF_WRITE_FIRST (RF_WRITE_FIRST)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_we_i),
    .waddr   (wb_addr_i),
    .wdata   (wb_data_i),
    .raddr_a (rs_addr_s),
    .rdata_a (rf_rs_data_s),
    .raddr_b (rt_addr_s),
    .rdata_b (rf_rt_data_s)
  );

  // MEM ALU results win over WB, which wins over the register file; loads in MEM are not forwardable
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            mem_we,
    input logic            mem_is_load,
    input logic [4:0]      mem_rd,
    input logic [XLEN-1:0] mem_data,
    input logic            wb_we,
    input logic [4:0]      wb_addr,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] res;
    if (addr == REG_ZERO) begin
      res = '0;
    end else if (mem_we && !mem_is_load && (mem_rd == addr)) begin
      res = mem_data;
    end else if (wb_we && (wb_addr == addr)) begin
      res = wb_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  // Source-operand hazard: load-use, or a branch needing a value still in EX or a load in MEM
  function automatic logic src_hazard(
    input logic       used,
    input logic [4:0] addr,
    input logic       br,
    input logic       ex_we,
    input logic       ex_is_load,
    input logic [4:0] ex_rd,
    input logic       mem_we,
    input logic       mem_is_load,
    input logic [4:0] mem_rd
  );
    logic ex_hit, mem_hit;
    ex_hit  = ex_we && (ex_rd == addr);
    mem_hit = mem_we && mem_is_load && (mem_rd == addr);
    return used && (addr != REG_ZERO) &&
           ((ex_hit && ex_is_load) || (br && ex_hit) || (br && mem_hit));
  endfunction

  // Operand forwarding, hazard detection and immediate/target formation
  always_comb begin
    rs_fwd_s = fwd_sel(rs_addr_s, rf_rs_data_s, mem_we_i, mem_is_load_i, mem_rd_i,
                       mem_data_i, wb_we_i, wb_addr_i, wb_data_i);
    rt_fwd_s = fwd_sel(rt_addr_s, rf_rt_data_s, mem_we_i, mem_is_load_i, mem_rd_i,
                       mem_data_i, wb_we_i, wb_addr_i, wb_data_i);
    bne_eff_s = HAS_BNE && is_bne_i;
    is_br_s   = is_beq_i || bne_eff_s || is_jr_i;
    haz_rs_s  = src_hazard(uses_rs_i, rs_addr_s, is_br_s, ex_we_i, ex_is_load_i, ex_rd_i,
                           mem_we_i, mem_is_load_i, mem_rd_i);
    haz_rt_s  = src_hazard(uses_rt_i, rt_addr_s, is_br_s, ex_we_i, ex_is_load_i, ex_rd_i,
                           mem_we_i, mem_is_load_i, mem_rd_i);
    stall_s   = id_valid_i && (haz_rs_s || haz_rt_s);
    eq_s      = (rs_fwd_s == rt_fwd_s);
    if (sext_i) begin
      imm_s = {{(XLEN-16){inst_i[15]}}, inst_i[15:0]};
    end else begin
      imm_s = {{(XLEN-16){1'b0}}, inst_i[15:0]};
    end
    br_target_s  = pc4_i + {imm_s[XLEN-3:0], 2'b00};
    jmp_target_s = {pc4_i[XLEN-1:28], inst_i[25:0], 2'b00};
  end

  // Redirect source with jr > jump > beq > bne priority
  always_comb begin
    redir_src_s = RDIR_NONE;
    if (is_jr_i) begin
      redir_src_s = RDIR_JR;
    end else if (is_jump_i) begin
      redir_src_s = RDIR_JUMP;
    end else if (is_beq_i) begin
      redir_src_s = RDIR_BEQ;
    end else if (bne_eff_s) begin
      redir_src_s = RDIR_BNE;
    end else begin
      redir_src_s = RDIR_NONE;
    end
  end

  // Redirect decision and target mux
  always_comb begin
    redirect_s = 1'b0;
    pc_next_s  = br_target_s;
    case (redir_src_s)
      RDIR_JR: begin
        redirect_s = 1'b1;
        pc_next_s  = rs_fwd_s;
      end
      RDIR_JUMP: begin
        redirect_s = 1'b1;
        pc_next_s  = jmp_target_s;
      end
      RDIR_BEQ: begin
        redirect_s = eq_s;
        pc_next_s  = br_target_s;
      end
      RDIR_BNE: begin
        redirect_s = !eq_s;
        pc_next_s  = br_target_s;
      end
      default: begin
        redirect_s = 1'b0;
        pc_next_s  = br_target_s;
      end
    endcase
  end

  assign stall_o    = stall_s;
  assign redirect_o = id_valid_i && !stall_s && redirect_s;
  assign pc_next_o  = pc_next_s;

  // ID/EX register: bubble on stall or empty ID, otherwise capture the decoded instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r   <= 1'b0;
      ex_pc4_r     <= '0;
      ex_rs_data_r <= '0;
      ex_rt_data_r <= '0;
      ex_imm_r     <= '0;
      ex_rs_r      <= 5'd0;
      ex_rt_r      <= 5'd0;
      ex_rd_r      <= 5'd0;
      ex_ctrl_r    <= '0;
    end else if (stall_s || !id_valid_i) begin
      ex_valid_r   <= 1'b0;
      ex_pc4_r     <= '0;
      ex_rs_data_r <= '0;
      ex_rt_data_r <= '0;
      ex_imm_r     <= '0;
      ex_rs_r      <= 5'd0;
      ex_rt_r      <= 5'd0;
      ex_rd_r      <= 5'd0;
      ex_ctrl_r    <= '0;
    end else begin
      ex_valid_r   <= 1'b1;
      ex_pc4_r     <= pc4_i;
      ex_rs_data_r <= rs_fwd_s;
      ex_rt_data_r <= rt_fwd_s;
      ex_imm_r     <= imm_s;
      ex_rs_r      <= rs_addr_s;
      ex_rt_r      <= rt_addr_s;
      ex_rd_r      <= rd_addr_s;
      ex_ctrl_r    <= ctrl_i;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign ex_valid_o   = ex_valid_r;
  assign ex_pc4_o     = ex_pc4_r;
  assign ex_rs_data_o = ex_rs_data_r;
  assign ex_rt_data_o = ex_rt_data_r;
  assign ex_imm_o     = ex_imm_r;
  assign ex_rs_o      = ex_rs_r;
  assign ex_rt_o      = ex_rt_r;
  assign ex_rd_o      = ex_rd_r;
  assign ex_ctrl_o    = ex_ctrl_r;
  assign stall_cnt_o  = stall_cnt_r;

endmodule
